// File: rtl/exception_handler.sv
// Exception consumer: freezes and flushes the pipeline, then vectors fetch to a per-cause handler.
// Optional macro DOUBLE_FAULT_EN adds a HALT state entered on an exception raised inside the handler.
module exception_handler #(
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0010,
  parameter logic [31:0] VECTOR_STRIDE = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception_in,
  input  logic        exception_ID_in,
  input  logic        exception_EXE_in,
  input  logic        exception_MEM_in,
  input  logic [2:0]  CAUSE_in,
  input  logic [31:0] EPC_in,
  input  logic        rti_in,
  output logic        stall_out,
  output logic [3:0]  flush_out,
  output logic        pc_redirect_out,
  output logic [31:0] pc_target_out,
  output logic        in_handler_out,
  output logic [2:0]  saved_cause_out,
  output logic [31:0] saved_epc_out,
  output logic        double_fault_out
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    REDIRECT,
    HANDLER,
    RETURN
`ifdef DOUBLE_FAULT_EN
    , HALT
`endif
  } state_t;

  state_t      state, state_next;
  logic [3:0]  origin_mask;
  logic [3:0]  origin_mask_next;

  // The oldest faulting stage decides how deep the flush reaches; no flag means flush everything.
  always_comb begin
    origin_mask_next = 4'b1111;
    if (exception_MEM_in)      origin_mask_next = 4'b1111;
    else if (exception_EXE_in) origin_mask_next = 4'b0111;
    else if (exception_ID_in)  origin_mask_next = 4'b0011;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      origin_mask     <= 4'b0000;
      saved_cause_out <= 3'd0;
      saved_epc_out   <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && exception_in)
        origin_mask <= origin_mask_next;
      if (state == CAPTURE) begin
        saved_cause_out <= CAUSE_in;
        saved_epc_out   <= EPC_in;
      end
    end
  end

  always_comb begin
    state_next       = state;
    stall_out        = 1'b0;
    flush_out        = 4'b0000;
    pc_redirect_out  = 1'b0;
    pc_target_out    = 32'd0;
    in_handler_out   = 1'b0;
    double_fault_out = 1'b0;
    case (state)
      IDLE: begin
        if (exception_in) begin
          stall_out  = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        stall_out  = 1'b1;
        state_next = (CAUSE_in == 3'd0) ? IDLE : FLUSH;
      end
      FLUSH: begin
        stall_out  = 1'b1;
        flush_out  = origin_mask;
        state_next = REDIRECT;
      end
      REDIRECT: begin
        stall_out       = 1'b1;
        pc_redirect_out = 1'b1;
        pc_target_out   = VECTOR_BASE + {29'd0, saved_cause_out} * VECTOR_STRIDE;
        state_next      = HANDLER;
      end
      HANDLER: begin
        in_handler_out = 1'b1;
`ifdef DOUBLE_FAULT_EN
        if (exception_in)  state_next = HALT;
        else if (rti_in)   state_next = RETURN;
`else
        if (rti_in)        state_next = RETURN;
`endif
      end
      RETURN: begin
        stall_out       = 1'b1;
        pc_redirect_out = 1'b1;
        pc_target_out   = saved_epc_out + 32'd1;
        flush_out       = 4'b0001;
        state_next      = IDLE;
      end
`ifdef DOUBLE_FAULT_EN
      HALT: begin
        stall_out        = 1'b1;
        flush_out        = 4'b1111;
        double_fault_out = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
    // State is already IDLE under reset; gate the combinational raise term too.
    if (!reset) stall_out = 1'b0;
  end

endmodule
